// File: rtl/bsg_fma_pkg.sv
// Types and helpers shared by the bsg_fma multiplier and its downstream accumulator.
package bsg_fma_pkg;

    typedef enum logic [0:0] {
        eAcc  = 1'b0,
        eDone = 1'b1
    } bsg_fma_acc_state_e;

    // Width of one packed operand / product word.
    function automatic int bsg_fma_width(input int exp_p, input int sig_p);
        return exp_p + sig_p + 1;
    endfunction

endpackage

// File: rtl/bsg_fma_acc_cnt.sv
// Clearable up-counter holding the number of terms in the running accumulation.
module bsg_fma_acc_cnt #(
    parameter int width_p = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (up_i) begin
            count_d = count_q + width_p'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_fma_acc.sv
// Modulo-2^width accumulator for bsg_fma product words: terms in over valid/ready,
// sum, term count and sticky carry out over valid/yumi.
module bsg_fma_acc
    import bsg_fma_pkg::*;
#(
    parameter int exp_p = 8,
    parameter int sig_p = 23,
    parameter int els_p = 16,
    localparam int width_lp     = bsg_fma_width(exp_p, sig_p),
    localparam int cnt_width_lp = $clog2(els_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [width_lp-1:0]     data_i,
    input  logic                    v_i,
    input  logic                    last_i,
    output logic                    ready_o,
    output logic [width_lp-1:0]     data_o,
    output logic [cnt_width_lp-1:0] count_o,
    output logic                    carry_o,
    output logic                    v_o,
    input  logic                    yumi_i
);

    // Input side:  a term moves when v_i & ready_o at a rising edge.
    // Output side: the result moves when v_o & yumi_i; yumi_i without v_o is illegal.
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(els_p - 1);

    bsg_fma_acc_state_e state_q, state_d;
    logic [width_lp-1:0]     acc_q, acc_d;
    logic [width_lp-1:0]     data_q, data_d;
    logic [cnt_width_lp-1:0] count_q, count_d;
    logic                    carry_q, carry_d;
    logic                    res_carry_q, res_carry_d;
    logic [cnt_width_lp-1:0] cnt;
    logic [width_lp:0]       sum;
    logic                    accept, close, clear;

    assign accept = v_i & (state_q == eAcc);
    assign clear  = yumi_i & (state_q == eDone);
    assign sum    = {1'b0, acc_q} + {1'b0, data_i};
    // The term limit closes the accumulation even without last_i.
    assign close  = accept & (last_i | (cnt == last_cnt_lp));

    bsg_fma_acc_cnt #(
        .width_p (cnt_width_lp)
    ) cnt_u (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear),
        .up_i    (accept),
        .count_o (cnt)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        carry_d     = carry_q;
        data_d      = data_q;
        count_d     = count_q;
        res_carry_d = res_carry_q;
        if (accept) begin
            acc_d   = sum[width_lp-1:0];
            carry_d = carry_q | sum[width_lp];
            if (close) begin
                data_d      = sum[width_lp-1:0];
                count_d     = cnt + cnt_width_lp'(1);
                res_carry_d = carry_q | sum[width_lp];
                state_d     = eDone;
            end
        end else if (clear) begin
            acc_d   = '0;
            carry_d = 1'b0;
            state_d = eAcc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= eAcc;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            data_q      <= '0;
            count_q     <= '0;
            res_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            carry_q     <= carry_d;
            data_q      <= data_d;
            count_q     <= count_d;
            res_carry_q <= res_carry_d;
        end
    end

    assign ready_o = (state_q == eAcc);
    assign v_o     = (state_q == eDone);
    assign data_o  = data_q;
    assign count_o = count_q;
    assign carry_o = res_carry_q;

    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_fma_acc.sv
// Bench for bsg_fma_acc: two instances (default els_p=16 and els_p=4) against a
// sum/count reference model built from unbounded integer arithmetic.
module tb_bsg_fma_acc;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic           in_v[2], in_last[2], yumi[2];
    logic           ready[2], out_v[2], out_carry[2];
    logic [W-1:0]   in_data[2], out_data[2];
    logic [4:0]     cnt_a;
    logic [2:0]     cnt_b;

    longint unsigned msum[2];
    int              mcnt[2];
    bit              allow_gaps;
    int              tests = 0;
    int              fails = 0;

    bsg_fma_acc u_dut_a (
        .clk_i(clk), .reset_i(reset), .data_i(in_data[0]), .v_i(in_v[0]), .last_i(in_last[0]),
        .ready_o(ready[0]), .data_o(out_data[0]), .count_o(cnt_a), .carry_o(out_carry[0]),
        .v_o(out_v[0]), .yumi_i(yumi[0])
    );

    bsg_fma_acc #(.els_p(4)) u_dut_b (
        .clk_i(clk), .reset_i(reset), .data_i(in_data[1]), .v_i(in_v[1]), .last_i(in_last[1]),
        .ready_o(ready[1]), .data_o(out_data[1]), .count_o(cnt_b), .carry_o(out_carry[1]),
        .v_o(out_v[1]), .yumi_i(yumi[1])
    );

    function automatic logic [4:0] get_count(input int idx);
        return (idx == 0) ? cnt_a : {2'b00, cnt_b};
    endfunction

    function automatic int els_of(input int idx);
        return (idx == 0) ? 16 : 4;
    endfunction

    function automatic logic [W-1:0] exp_data(input int idx);
        return msum[idx][W-1:0];
    endfunction

    function automatic logic exp_carry(input int idx);
        return (msum[idx] >> W) != 0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            msum[i] = 0;
            mcnt[i] = 0;
        end
    endtask

    // Offer one term and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input int idx, input logic [W-1:0] d, input logic l);
        int waited = 0;
        if (allow_gaps && $urandom_range(0, 3) == 0) begin
            in_v[idx] = 1'b0;
            @(posedge clk); #1;
        end
        in_v[idx] = 1'b1;
        in_data[idx] = d;
        in_last[idx] = l;
        @(negedge clk);
        while (!ready[idx] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (waited >= 40) begin
            fails++;
            $display("FAIL send_timeout dut%0d: ready_o=%0b after %0d cycles, required 1", idx, ready[idx], waited);
        end else begin
            msum[idx] += longint'(d);
            mcnt[idx]++;
        end
        @(posedge clk); #1;
    endtask

    task automatic collect(input int idx, input string name, output int lat);
        int waited = 0;
        in_v[idx] = 1'b0;
        in_last[idx] = 1'b0;
        while (!out_v[idx] && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        lat = waited;
        tests++;
        if (out_v[idx] !== 1'b1) begin
            fails++;
            $display("FAIL %s_v dut%0d: v_o=%0b, required 1", name, idx, out_v[idx]);
        end
        tests++;
        if (out_data[idx] !== exp_data(idx)) begin
            fails++;
            $display("FAIL %s_data dut%0d: data_o=%h, required %h", name, idx, out_data[idx], exp_data(idx));
        end
        tests++;
        if (get_count(idx) !== 5'(mcnt[idx])) begin
            fails++;
            $display("FAIL %s_count dut%0d: count_o=%0d, required %0d", name, idx, get_count(idx), mcnt[idx]);
        end
        tests++;
        if (out_carry[idx] !== exp_carry(idx)) begin
            fails++;
            $display("FAIL %s_carry dut%0d: carry_o=%0b, required %0b", name, idx, out_carry[idx], exp_carry(idx));
        end
        yumi[idx] = 1'b1;
        @(posedge clk); #1;
        yumi[idx] = 1'b0;
        tests++;
        if (out_v[idx] !== 1'b0 || ready[idx] !== 1'b1) begin
            fails++;
            $display("FAIL %s_release dut%0d: v_o=%0b ready_o=%0b, required 0 1", name, idx, out_v[idx], ready[idx]);
        end
        msum[idx] = 0;
        mcnt[idx] = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (ready[i] !== 1'b1 || out_v[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_hs dut%0d: ready_o=%0b v_o=%0b, required 1 0", i, ready[i], out_v[i]);
            end
            tests++;
            if (out_data[i] !== '0 || get_count(i) !== '0 || out_carry[i] !== 1'b0) begin
                fails++;
                $display("FAIL reset_out dut%0d: data_o=%h count_o=%0d carry_o=%0b, required 0 0 0",
                         i, out_data[i], get_count(i), out_carry[i]);
            end
        end
    endtask

    task automatic test_three_terms();
        int lat;
        allow_gaps = 1'b0;
        send(0, 32'h10, 1'b0);
        send(0, 32'h20, 1'b0);
        send(0, 32'h30, 1'b1);
        collect(0, "three", lat);
        tests++;
        if (lat != 0) begin
            fails++;
            $display("FAIL three_latency: v_o rose %0d cycles late, required 0", lat);
        end
    endtask

    task automatic test_wrap();
        int lat;
        send(0, 32'hFFFF_FFFF, 1'b0);
        send(0, 32'h0000_0002, 1'b1);
        collect(0, "wrap", lat);
    endtask

    task automatic test_forced_close();
        int accepted = 0;
        int lat;
        in_v[1] = 1'b1;
        in_data[1] = 32'h1;
        in_last[1] = 1'b0;
        for (int c = 0; c < 20 && !out_v[1]; c++) begin
            @(negedge clk);
            if (ready[1]) accepted++;
            @(posedge clk); #1;
        end
        msum[1] = longint'(accepted);
        mcnt[1] = accepted;
        tests++;
        if (accepted != 4 || out_v[1] !== 1'b1 || ready[1] !== 1'b0) begin
            fails++;
            $display("FAIL forced_close: accepted=%0d v_o=%0b ready_o=%0b, required 4 1 0", accepted, out_v[1], ready[1]);
        end
        tests++;
        if (out_data[1] !== 32'h4 || cnt_b !== 3'd4) begin
            fails++;
            $display("FAIL forced_result: data_o=%h count_o=%0d, required 4 4", out_data[1], cnt_b);
        end
        @(negedge clk);
        tests++;
        if (ready[1] !== 1'b0) begin
            fails++;
            $display("FAIL forced_fifth_held: ready_o=%0b, required 0", ready[1]);
        end
        @(posedge clk); #1;
        yumi[1] = 1'b1;
        @(posedge clk); #1;
        yumi[1] = 1'b0;
        msum[1] = 0;
        mcnt[1] = 0;
        send(1, 32'h1, 1'b0);
        send(1, 32'h8, 1'b1);
        collect(1, "forced_next", lat);
    endtask

    task automatic test_backpressure();
        int lat;
        send(0, 32'h11, 1'b0);
        send(0, 32'h22, 1'b1);
        in_v[0] = 1'b1;
        in_data[0] = 32'h7;
        in_last[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tests++;
            if (ready[0] !== 1'b0 || out_v[0] !== 1'b1 || out_data[0] !== exp_data(0)
                || get_count(0) !== 5'(mcnt[0]) || out_carry[0] !== exp_carry(0)) begin
                fails++;
                $display("FAIL backpressure_hold c%0d: ready_o=%0b v_o=%0b data_o=%h count_o=%0d, required 0 1 %h %0d",
                         c, ready[0], out_v[0], out_data[0], get_count(0), exp_data(0), mcnt[0]);
            end
            @(posedge clk); #1;
        end
        yumi[0] = 1'b1;
        @(posedge clk); #1;
        yumi[0] = 1'b0;
        msum[0] = 0;
        mcnt[0] = 0;
        tests++;
        if (out_v[0] !== 1'b0 || ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: v_o=%0b ready_o=%0b, required 0 1", out_v[0], ready[0]);
        end
        send(0, 32'h7, 1'b1);
        collect(0, "backpressure_next", lat);
    endtask

    task automatic test_reset_mid();
        int lat;
        send(0, 32'h5, 1'b0);
        send(0, 32'h6, 1'b0);
        in_v[0] = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear_model();
        tests++;
        if (ready[0] !== 1'b1 || out_v[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_state: ready_o=%0b v_o=%0b, required 1 0", ready[0], out_v[0]);
        end
        send(0, 32'h9, 1'b1);
        collect(0, "reset_mid", lat);
    endtask

    task automatic test_random(input int idx, input int packets);
        int n, lat;
        logic l;
        allow_gaps = 1'b1;
        for (int p = 0; p < packets; p++) begin
            n = $urandom_range(1, els_of(idx));
            for (int k = 1; k <= n; k++) begin
                if (k < n) l = 1'b0;
                else if (n < els_of(idx)) l = 1'b1;
                else l = 1'($urandom_range(0, 1));
                send(idx, $urandom, l);
            end
            collect(idx, "random", lat);
        end
        allow_gaps = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        allow_gaps = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_v[i] = 1'b0;
            in_last[i] = 1'b0;
            in_data[i] = '0;
            yumi[i] = 1'b0;
        end
        test_reset();
        test_three_terms();
        test_wrap();
        test_forced_close();
        test_backpressure();
        test_reset_mid();
        test_random(0, 20);
        test_random(1, 20);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_fma_acc.md
# bsg_fma_acc

Sequential accumulator that sits directly downstream of the packed-operand multiplier `bsg_fma`. It consumes its `width_lp`-bit product words over a valid/ready handshake and sums them modulo 2^`width_lp`. On a `last` marker, or when the term limit is reached, it presents the sum, the term count and a sticky carry flag over a valid/yumi handshake. This is the algorithm-level multiply-accumulate path used to check dot-product style sequences against the multiplier.

## Interface
- `exp_p`, default 8: exponent field width; matches `bsg_fma`.
- `sig_p`, default 23: significand field width; matches `bsg_fma`.
- `els_p`, default 16: maximum terms per accumulation; must be ≥ 1.
- `width_lp`, localparam: `exp_p + sig_p + 1`.
- `cnt_width_lp`, localparam: `$clog2(els_p+1)`.

- `clk_i` input 1: the single clock.
- `reset_i` input 1: synchronous, active-high reset.
- `data_i` input `width_lp`: product word, i.e. `bsg_fma.mul_o`.
- `v_i` input 1: `data_i` and `last_i` are valid.
- `last_i` input 1: this term closes the accumulation.
- `ready_o` output 1: the block accepts a term this cycle.
- `data_o` output `width_lp`: accumulated sum.
- `count_o` output `cnt_width_lp`: number of terms in `data_o`, from 1 to `els_p`.
- `carry_o` output 1: sticky flag; at least one addition carried out of bit `width_lp-1`.
- `v_o` output 1: the result outputs are valid.
- `yumi_i` input 1: consumer takes the result. Legal only while `v_o` is 1.

## Operation
- FSM with two states: `eAcc` and `eDone`. Reset state is `eAcc`.
- **In `eAcc`:**
  - `ready_o`=1 and `v_o`=0.
  - A term is accepted when `v_i & ready_o`.
  - On acceptance: `acc <= acc + data_i`, truncated to `width_lp` bits.
  - On acceptance: `cnt <= cnt + 1`.
  - On acceptance: `carry <= carry | carry-out` of that addition.
- **Closing the accumulation:**
  - Closing condition: `last_i`, or `cnt == els_p-1`. The limit forces a close even when `last_i`=0.
  - On closing acceptance: `data_o`, `count_o` and `carry_o` load the post-add values, and the FSM moves to `eDone`.
- **In `eDone`:**
  - `ready_o`=0 and `v_o`=1.
  - Outputs stay stable until `yumi_i`.
  - On `yumi_i`: `acc`, `cnt` and `carry` clear to 0, and the FSM returns to `eAcc`.
- `v_i` while in `eDone` is ignored; the upstream stage must hold its data.
- `yumi_i` while `v_o`=0 is illegal. An assertion flags it; the RTL ignores it.
- `data_i` is treated as an unsigned integer. No floating-point normalization or rounding is done; this matches the integer semantics of `bsg_fma`.
- `els_p`=1: every accepted term closes immediately, with `count_o`=1.

## Timing
- Reset values:
  - `ready_o`=1, `v_o`=0.
  - `data_o`=0, `count_o`=0, `carry_o`=0.
  - Internal `acc`, `cnt` and `carry` are all 0.
- Closing latency: term accepted at edge N, so `v_o`=1 from the cycle after edge N. There is no combinational path from `v_i`/`data_i` to `v_o`/`data_o`.
- `ready_o` depends only on FSM state, never combinationally on `v_i` or `yumi_i`.
- Yumi and new data in the same cycle: `yumi_i` at edge M gives `ready_o`=1 in the following cycle. The first term of the next accumulation is accepted no earlier than edge M+1. The result is not bypassed into a same-cycle re-accept.
- Throughput:
  - One term per cycle while in `eAcc`.
  - Minimum of one bubble cycle between accumulations: the `eDone` cycle.
- Reset mid-operation: `reset_i` at any edge discards the partial sum and any pending result. The block returns to reset values at the next cycle, regardless of `v_i` or `yumi_i`.
- Wrap-around: the sum is modulo 2^`width_lp`. `carry_o` records any wrap and never clears before `yumi_i` or reset.

## Structure
- Shared package `bsg_fma_pkg` holds:
  - state enum `bsg_fma_acc_state_e` {`eAcc`, `eDone`};
  - function `bsg_fma_width(exp_p, sig_p)` returning `exp_p+sig_p+1`, used by both `bsg_fma` and this block.
- Natural sub-module: `bsg_fma_acc_cnt`, a clearable up-counter (`clear_i`, `up_i`, `count_o`, width `cnt_width_lp`) used for `cnt`.
- Everything else is inline: adder with carry-out, result register, FSM.

## Test plan
- **Reset:** assert `reset_i` 2 cycles. Required: `ready_o`=1, `v_o`=0, `data_o`=0, `count_o`=0, `carry_o`=0.
- **Three terms:** 0x10, 0x20, 0x30, the last with `last_i`=1, back-to-back. Required:
  - `v_o`=1 the cycle after the third accept;
  - `data_o`=0x60, `count_o`=3, `carry_o`=0.
- **Wrap, default widths:** 0xFFFFFFFF then 0x00000002 with `last_i`. Required: `data_o`=0x00000001, `carry_o`=1, `count_o`=2.
- **Forced close:** `els_p`=4, stream 5 terms of 1 with `last_i`=0.
  - Required after 4 accepts: `v_o`=1, `data_o`=4, `count_o`=4, `ready_o`=0, and the 5th term not accepted.
  - Required after `yumi_i`: the 5th term is accepted as term 1 of the next accumulation.
- **Backpressure:** hold `yumi_i`=0 for 5 cycles in `eDone` while `v_i`=1. Required:
  - outputs stable throughout;
  - no term accepted;
  - after `yumi_i`, `acc` restarts from 0, so the next single `last_i` term 0x7 gives `data_o`=0x7.
- **Reset mid-accumulation:** accept 0x5 and 0x6, then assert `reset_i` for 1 cycle, then send 0x9 with `last_i`. Required: `data_o`=0x9, `count_o`=1.
